// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions: ALU option codes, opcode/funct constants,
// the decoded issue bundle and small field-extension helpers.
package mips_pkg;

  // ALU option codes driven on the ALU option input
  localparam logic [3:0] OPT_AND  = 4'b0000;
  localparam logic [3:0] OPT_OR   = 4'b0001;
  localparam logic [3:0] OPT_ADD  = 4'b0010;
  localparam logic [3:0] OPT_XOR  = 4'b0011;
  localparam logic [3:0] OPT_SLL  = 4'b0100;
  localparam logic [3:0] OPT_SRL  = 4'b0101;
  localparam logic [3:0] OPT_SUB  = 4'b0110;
  localparam logic [3:0] OPT_SLT  = 4'b0111;
  localparam logic [3:0] OPT_MUL  = 4'b1000;
  localparam logic [3:0] OPT_DIV  = 4'b1001;
  localparam logic [3:0] OPT_SRA  = 4'b1010;
  localparam logic [3:0] OPT_NOR  = 4'b1100;
  localparam logic [3:0] OPT_LUI  = 4'b1101;
  localparam logic [3:0] OPT_BNE  = 4'b1110;
  localparam logic [3:0] OPT_MOVE = 4'b1111;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_SLLV = 6'h04;
  localparam logic [5:0] FN_SRLV = 6'h06;
  localparam logic [5:0] FN_MULT = 6'h18;
  localparam logic [5:0] FN_DIV  = 6'h1A;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  typedef struct packed {
    logic [31:0] oprd1;
    logic [31:0] oprd2;
    logic [3:0]  option;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        illegal;
  } issue_bundle_t;

  function automatic logic [31:0] sign_ext16(input logic [15:0] imm);
    return {{16{imm[15]}}, imm};
  endfunction

  function automatic logic [31:0] zero_ext16(input logic [15:0] imm);
    return {16'h0000, imm};
  endfunction

  function automatic issue_bundle_t make_bundle(
    input logic [3:0]  opt,
    input logic [31:0] a,
    input logic [31:0] b,
    input logic [4:0]  dst,
    input logic        wr
  );
    issue_bundle_t bnd;
    bnd.oprd1     = a;
    bnd.oprd2     = b;
    bnd.option    = opt;
    bnd.dest_reg  = dst;
    bnd.reg_write = wr;
    bnd.illegal   = 1'b0;
    return bnd;
  endfunction

  // Unknown encodings become an inert bundle: no write-back, zero operands.
  function automatic issue_bundle_t illegal_bundle();
    issue_bundle_t bnd;
    bnd           = '0;
    bnd.illegal   = 1'b1;
    return bnd;
  endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS instruction decoder: maps an instruction and its
// register read values onto the ALU operand pair, option and write-back info.
module alu_issue_decode
  import mips_pkg::*;
(
  input  logic [31:0]   i_instr,
  input  logic [31:0]   i_rs_val,
  input  logic [31:0]   i_rt_val,
  output issue_bundle_t o_bundle
);

  logic [5:0]    w_opcode;
  logic [5:0]    w_funct;
  logic [4:0]    w_rt_idx;
  logic [4:0]    w_rd_idx;
  logic [31:0]   w_se;
  logic [31:0]   w_ze;
  logic [31:0]   w_sh;
  logic          w_unused_rs_idx;
  issue_bundle_t w_bundle;

  assign w_opcode = i_instr[31:26];
  assign w_funct  = i_instr[5:0];
  assign w_rt_idx = i_instr[20:16];
  assign w_rd_idx = i_instr[15:11];
  assign w_se     = sign_ext16(i_instr[15:0]);
  assign w_ze     = zero_ext16(i_instr[15:0]);
  assign w_sh     = {27'd0, i_instr[10:6]};

  // The rs index is consumed by the register file, not by this decoder.
  assign w_unused_rs_idx = ^i_instr[25:21];

  // Decode table; SRA swaps operands because the ALU shifts oprd1 by oprd2[4:0].
  always_comb begin
    w_bundle = illegal_bundle();
    case (w_opcode)
      OP_RTYPE: begin
        case (w_funct)
          FN_ADD, FN_ADDU: w_bundle = make_bundle(OPT_ADD, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_SUB, FN_SUBU: w_bundle = make_bundle(OPT_SUB, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_AND:          w_bundle = make_bundle(OPT_AND, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_OR:           w_bundle = make_bundle(OPT_OR,  i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_XOR:          w_bundle = make_bundle(OPT_XOR, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_NOR:          w_bundle = make_bundle(OPT_NOR, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_SLT:          w_bundle = make_bundle(OPT_SLT, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_SLL:          w_bundle = make_bundle(OPT_SLL, w_sh,     i_rt_val, w_rd_idx, 1'b1);
          FN_SRL:          w_bundle = make_bundle(OPT_SRL, w_sh,     i_rt_val, w_rd_idx, 1'b1);
          FN_SRA:          w_bundle = make_bundle(OPT_SRA, i_rt_val, w_sh,     w_rd_idx, 1'b1);
          FN_SLLV:         w_bundle = make_bundle(OPT_SLL, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_SRLV:         w_bundle = make_bundle(OPT_SRL, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_MULT:         w_bundle = make_bundle(OPT_MUL, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          FN_DIV:          w_bundle = make_bundle(OPT_DIV, i_rs_val, i_rt_val, w_rd_idx, 1'b1);
          default:         w_bundle = illegal_bundle();
        endcase
      end
      OP_ADDI, OP_ADDIU: w_bundle = make_bundle(OPT_ADD, i_rs_val, w_se,     w_rt_idx, 1'b1);
      OP_SLTI:           w_bundle = make_bundle(OPT_SLT, i_rs_val, w_se,     w_rt_idx, 1'b1);
      OP_ANDI:           w_bundle = make_bundle(OPT_AND, i_rs_val, w_ze,     w_rt_idx, 1'b1);
      OP_ORI:            w_bundle = make_bundle(OPT_OR,  i_rs_val, w_ze,     w_rt_idx, 1'b1);
      OP_XORI:           w_bundle = make_bundle(OPT_XOR, i_rs_val, w_ze,     w_rt_idx, 1'b1);
      OP_LUI:            w_bundle = make_bundle(OPT_LUI, 32'd0,    w_ze,     w_rt_idx, 1'b1);
      OP_LW:             w_bundle = make_bundle(OPT_ADD, i_rs_val, w_se,     w_rt_idx, 1'b1);
      OP_SW:             w_bundle = make_bundle(OPT_ADD, i_rs_val, w_se,     w_rt_idx, 1'b0);
      OP_BEQ:            w_bundle = make_bundle(OPT_SUB, i_rs_val, i_rt_val, w_rt_idx, 1'b0);
      OP_BNE:            w_bundle = make_bundle(OPT_BNE, i_rs_val, i_rt_val, w_rt_idx, 1'b0);
      default:           w_bundle = illegal_bundle();
    endcase
  end

  assign o_bundle = w_bundle;

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes an instruction into ALU operands/option and holds
// the result in a one-entry valid/ready register with flush and a saturating
// count of accepted illegal instructions.
module alu_issue_stage
  import mips_pkg::*;
#(
  parameter int ILL_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [31:0]          rs_val,
  input  logic [31:0]          rt_val,
  input  logic                 flush,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          oprd1,
  output logic [31:0]          oprd2,
  output logic [3:0]           option,
  output logic [4:0]           dest_reg,
  output logic                 reg_write,
  output logic                 illegal,
  output logic [ILL_CNT_W-1:0] ill_cnt
);

  localparam logic [ILL_CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ILL_CNT_W-1:0] CNT_ONE = {{(ILL_CNT_W-1){1'b0}}, 1'b1};

  issue_bundle_t        w_dec;
  logic                 w_accept;
  logic                 r_valid;
  issue_bundle_t        r_bundle;
  logic [ILL_CNT_W-1:0] r_ill_cnt;

  alu_issue_decode u_decode (
    .i_instr  (instr),
    .i_rs_val (rs_val),
    .i_rt_val (rt_val),
    .o_bundle (w_dec)
  );

  // The slot can take new data when it is empty or being drained this cycle.
  assign in_ready = !r_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Valid flag: flush wins over a same-cycle accept; a drained slot empties.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  // Data register only loads on accept, so it holds stable under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bundle <= '0;
    end else if (w_accept) begin
      r_bundle <= w_dec;
    end
  end

  // Count accepted, non-flushed illegal instructions, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ill_cnt <= '0;
    end else if (w_accept && !flush && w_dec.illegal && (r_ill_cnt != CNT_MAX)) begin
      r_ill_cnt <= r_ill_cnt + CNT_ONE;
    end
  end

  assign out_valid = r_valid;
  assign oprd1     = r_bundle.oprd1;
  assign oprd2     = r_bundle.oprd2;
  assign option    = r_bundle.option;
  assign dest_reg  = r_bundle.dest_reg;
  assign reg_write = r_bundle.reg_write;
  assign illegal   = r_bundle.illegal;
  assign ill_cnt   = r_ill_cnt;

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Pipeline stage directly upstream of the combinational ALU.
- Decodes a MIPS instruction plus its register-file read values into the ALU's operand pair and 4-bit option code.
- Registers the decoded fields in a one-entry valid/ready pipeline register with flush.
- This block is the producer end of the ALU operand/option interface; its outputs feed the ALU inputs directly.

Parameters:
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  upstream presents instr, rs_val and rt_val.
- in_ready  out  1  stage can accept the input this cycle.
- instr  in  32  MIPS instruction word.
- rs_val  in  32  value of register rs.
- rt_val  in  32  value of register rt.
- flush  in  1  discard the held entry and any same-cycle input.
- out_valid  out  1  registered outputs are valid.
- out_ready  in  1  downstream accepts the registered outputs.
- oprd1  out  32  ALU operand 1.
- oprd2  out  32  ALU operand 2.
- option  out  4  ALU operation code.
- dest_reg  out  5  write-back register index.
- reg_write  out  1  write-back enable.
- illegal  out  1  opcode/funct not in the decode table.
- ill_cnt  out  ILL_CNT_W  saturating count of accepted illegal instructions.

Behaviour:
- Reset (asynchronous, rst_n low): out_valid=0, oprd1=0, oprd2=0, option=4'b0000, dest_reg=0, reg_write=0, illegal=0, ill_cnt=0.
- Reset asserted mid-transfer drops the held entry.
- Handshake: in_ready = !out_valid || out_ready (combinational).
  - Input is accepted when in_valid && in_ready.
  - Data appears on the outputs the following cycle (latency 1).
  - Back-to-back transfers run at full throughput.
  - While out_valid && !out_ready, all outputs hold stable.
- Flush has priority:
  - out_valid <= 0 next cycle, even if an input is accepted the same cycle.
  - Data registers may take any value.
  - ill_cnt does not count a flushed instruction.
- Immediates:
  - SE = sign-extended instr[15:0].
  - ZE = zero-extended instr[15:0].
  - SH = zero-extended instr[10:6].
- R-type (opcode 0x00), format is funct -> option, oprd1, oprd2; dest_reg=rd, reg_write=1:
  - 0x20/0x21 add -> 0010, rs, rt.
  - 0x22/0x23 sub -> 0110, rs, rt.
  - 0x24 and -> 0000, rs, rt.
  - 0x25 or -> 0001, rs, rt.
  - 0x26 xor -> 0011, rs, rt.
  - 0x27 nor -> 1100, rs, rt.
  - 0x2A slt -> 0111, rs, rt.
  - 0x00 sll -> 0100, oprd1=SH, oprd2=rt.
  - 0x02 srl -> 0101, oprd1=SH, oprd2=rt.
  - 0x03 sra -> 1010, oprd1=rt, oprd2=SH. Operands are swapped because the ALU shifts oprd1 by oprd2[4:0] for SRA.
  - 0x04 sllv -> 0100, oprd1=rs, oprd2=rt.
  - 0x06 srlv -> 0101, oprd1=rs, oprd2=rt.
  - 0x18 mult -> 1000, rs, rt.
  - 0x1A div -> 1001, rs, rt.
- I-type, format is opcode -> option, oprd1, oprd2; dest_reg=rt:
  - 0x08/0x09 addi -> 0010, rs, SE.
  - 0x0A slti -> 0111, rs, SE.
  - 0x0C andi -> 0000, rs, ZE.
  - 0x0D ori -> 0001, rs, ZE.
  - 0x0E xori -> 0011, rs, ZE.
  - 0x0F lui -> 1101, oprd1=0, oprd2=ZE.
  - 0x23 lw -> 0010, rs, SE; reg_write=1.
  - 0x2B sw -> 0010, rs, SE; reg_write=0.
  - 0x04 beq -> 0110, rs, rt; reg_write=0. Taken when the ALU zero flag is 1.
  - 0x05 bne -> 1110, rs, rt; reg_write=0. The ALU returns 0 when operands differ, so zero=1 means taken.
  - All other ALU-writing I-types above use reg_write=1.
- Anything else:
  - illegal=1, option=0000, oprd1=oprd2=0, reg_write=0, dest_reg=0.
  - ill_cnt increments on acceptance and saturates at all-ones.
- Register 0 writes: reg_write is still 1 when dest_reg=0; squashing is the register file's job.

Decomposition:
- Shared package mips_pkg holds:
  - ALU option localparams: OPT_AND, OPT_OR, OPT_ADD, OPT_XOR, OPT_SLL, OPT_SRL, OPT_SUB, OPT_SLT, OPT_MUL, OPT_DIV, OPT_SRA, OPT_NOR, OPT_LUI, OPT_BNE, OPT_MOVE.
  - Opcode and funct constants.
  - Decoded-bundle struct: oprd1, oprd2, option, dest_reg, reg_write, illegal.
- Sub-module alu_issue_decode: purely combinational instruction-to-bundle decoder. The top level holds only the pipeline register, handshake and counter.

Test Plan:
- Reset: rst_n=0 for 3 cycles -> all outputs 0, in_ready=1. Release, present addi $2,$1,-1 (0x2022FFFF) with rs_val=5 -> next cycle option=0010, oprd1=5, oprd2=0xFFFFFFFF, dest_reg=2, reg_write=1.
- Shifts: sll $3,$4,4 (0x00041900) with rt_val=0x1 -> option=0100, oprd1=4, oprd2=1. sra $3,$4,4 (0x00041903) with rt_val=0x80000000 -> option=1010, oprd1=0x80000000, oprd2=4.
- Branch/lui: bne rs=7, rt=7 -> option=1110, reg_write=0. lui $5,0x1234 -> option=1101, oprd2=0x00001234, dest_reg=5.
- Backpressure: out_ready=0 for 4 cycles with in_valid=1 -> outputs frozen and in_ready=0. Release -> next instruction appears after exactly one cycle with none dropped or duplicated; a 10-instruction stream with out_ready=1 completes in 11 cycles.
- Flush: flush=1 in the same cycle an instruction is accepted -> out_valid=0 next cycle, ill_cnt unchanged.
- Illegal: 300 accepted 0xFC000000 words with ILL_CNT_W=8 -> illegal=1, reg_write=0, ill_cnt saturates at 255.
